// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO sequencer owning the HI/LO register pair.
// Fixed-latency multiply, 32-step restoring divide; stalls the pipeline while busy.
module muldiv_sequencer #(
    parameter int unsigned MUL_LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic        read_hi,
    input  logic        read_lo,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        stall,
    output logic        done
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 5;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_ITER = 2'd2,
        DIV_FIX  = 2'd3
    } state_t;

    state_t state, state_n;

    logic [CW-1:0]   cnt;
    logic [DW-1:0]   a_reg;      // original op1 (mul operand, dividend sign / div-by-zero HI)
    logic [DW-1:0]   b_reg;      // op2 for mul, divisor magnitude for div
    logic            is_signed;
    logic            sgn_b;
    logic [DW:0]     rem;
    logic [DW-1:0]   quo;

    logic acc_mul, acc_div, wr_mthi, wr_mtlo, mul_wr, div_wr, div_step, cnt_dec;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state and control decode
    always_comb begin
        state_n  = state;
        acc_mul  = 1'b0;
        acc_div  = 1'b0;
        wr_mthi  = 1'b0;
        wr_mtlo  = 1'b0;
        mul_wr   = 1'b0;
        div_wr   = 1'b0;
        div_step = 1'b0;
        cnt_dec  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            acc_mul = 1'b1;
                            state_n = MUL_WAIT;
                        end
                        OP_DIV, OP_DIVU: begin
                            acc_div = 1'b1;
                            state_n = DIV_ITER;
                        end
                        OP_MTHI: wr_mthi = 1'b1;
                        OP_MTLO: wr_mtlo = 1'b1;
                        default: ;
                    endcase
                end
            end
            MUL_WAIT: begin
                if (cnt == '0) begin
                    mul_wr  = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DIV_ITER: begin
                div_step = 1'b1;
                if (cnt == '0) state_n = DIV_FIX;
                else           cnt_dec = 1'b1;
            end
            DIV_FIX: begin
                div_wr  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath: operand sign handling, product, restoring step, sign fix-up
    logic            op1_neg, op2_neg;
    logic [DW-1:0]   op1_mag, op2_mag;
    logic [2*DW-1:0] product;
    logic [DW+1:0]   shifted;
    logic            ge;
    logic [DW:0]     rem_next;
    logic [DW-1:0]   quo_fix, rem_fix, div_lo, div_hi;
    logic            q_neg, r_neg, div0;

    always_comb begin
        op1_neg  = (op == OP_DIV) && op1[DW-1];
        op2_neg  = (op == OP_DIV) && op2[DW-1];
        op1_mag  = op1_neg ? DW'(-op1) : op1;
        op2_mag  = op2_neg ? DW'(-op2) : op2;
        product  = {{DW{a_reg[DW-1] & is_signed}}, a_reg} *
                   {{DW{b_reg[DW-1] & is_signed}}, b_reg};
        shifted  = {rem, quo[DW-1]};
        ge       = shifted >= {2'b00, b_reg};
        rem_next = ge ? (DW+1)'(shifted - {2'b00, b_reg}) : (DW+1)'(shifted);
        q_neg    = is_signed & (a_reg[DW-1] ^ sgn_b);
        r_neg    = is_signed & a_reg[DW-1];
        quo_fix  = q_neg ? DW'(-quo) : quo;
        rem_fix  = r_neg ? DW'(-rem[DW-1:0]) : rem[DW-1:0];
        div0     = (b_reg == '0);
        div_lo   = div0 ? '1 : quo_fix;
        div_hi   = div0 ? a_reg : rem_fix;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            is_signed <= 1'b0;
            sgn_b     <= 1'b0;
            rem       <= '0;
            quo       <= '0;
            hi_out    <= '0;
            lo_out    <= '0;
            done      <= 1'b0;
        end else begin
            done <= mul_wr | div_wr;
            if (cnt_dec) cnt <= cnt - CW'(1);
            if (acc_mul) begin
                a_reg     <= op1;
                b_reg     <= op2;
                is_signed <= (op == OP_MULT);
                cnt       <= CW'(MUL_LATENCY - 1);
            end
            if (acc_div) begin
                a_reg     <= op1;
                b_reg     <= op2_mag;
                is_signed <= (op == OP_DIV);
                sgn_b     <= op2[DW-1];
                rem       <= '0;
                quo       <= op1_mag;
                cnt       <= CW'(31);
            end
            if (div_step) begin
                rem <= rem_next;
                quo <= {quo[DW-2:0], ge};
            end
            if (wr_mthi) hi_out <= op1;
            if (wr_mtlo) lo_out <= op1;
            if (mul_wr) begin
                hi_out <= product[2*DW-1:DW];
                lo_out <= product[DW-1:0];
            end
            if (div_wr) begin
                hi_out <= div_hi;
                lo_out <= div_lo;
            end
        end
    end

    assign busy  = (state != IDLE);
    assign stall = busy & (start | read_hi | read_lo);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer: mul/div results, latency, stall,
// divide-by-zero, overflow, reset abort and MTHI/MTLO.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] op1, op2;
    logic        read_hi, read_lo;
    logic [31:0] hi_out, lo_out;
    logic        busy, stall, done;

    int total = 0;
    int bad   = 0;
    int cyc;

    muldiv_sequencer #(.MUL_LATENCY(4)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .op1(op1), .op2(op2),
        .read_hi(read_hi), .read_lo(read_lo), .hi_out(hi_out), .lo_out(lo_out),
        .busy(busy), .stall(stall), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op and wait (bounded) for busy to drop; cyc = busy cycles seen
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        start = 1'b1; op = o; op1 = a; op2 = b;
        tick();
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; op1 = '0; op2 = '0;
        read_hi = 1'b0; read_lo = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_hi", hi_out, 32'h0);
        chk("rst_lo", lo_out, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        run_op(3'd0, 32'hFFFF_FFFF, 32'd2, cyc);
        chk("mult_lat", 32'(cyc), 32'd4);
        chk("mult_hi", hi_out, 32'hFFFF_FFFF);
        chk("mult_lo", lo_out, 32'hFFFF_FFFE);
        chk("mult_done", 32'(done), 32'd1);
        tick();
        chk("mult_done_off", 32'(done), 32'd0);

        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, cyc);
        chk("multu_lat", 32'(cyc), 32'd4);
        chk("multu_hi", hi_out, 32'h0000_0001);
        chk("multu_lo", lo_out, 32'hFFFF_FFFE);

        run_op(3'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, cyc);
        chk("mult_nn_hi", hi_out, 32'h0);
        chk("mult_nn_lo", lo_out, 32'd15);

        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, cyc);
        chk("div_lat", 32'(cyc), 32'd33);
        chk("div_lo", lo_out, 32'hFFFF_FFFD);
        chk("div_hi", hi_out, 32'hFFFF_FFFF);
        chk("div_done", 32'(done), 32'd1);
        tick();

        // DIVU 7/2 while read_lo held and an MTHI issued mid-flight
        read_lo = 1'b1;
        start = 1'b1; op = 3'd3; op1 = 32'd7; op2 = 32'd2;
        tick();
        start = 1'b0; op = 3'd4; op1 = 32'hDEAD_BEEF;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            chk("rd_stall", 32'(stall), 32'd1);
            chk("rd_lo_old", lo_out, 32'hFFFF_FFFD);
            chk("rd_hi_old", hi_out, 32'hFFFF_FFFF);
            start = (cyc == 5);
            cyc++;
            tick();
        end
        start = 1'b0;
        chk("divu_lat", 32'(cyc), 32'd33);
        chk("rd_stall_idle", 32'(stall), 32'd0);
        chk("rd_done", 32'(done), 32'd1);
        chk("divu_lo", lo_out, 32'd3);
        chk("divu_hi", hi_out, 32'd1);
        read_lo = 1'b0;
        tick();
        chk("ignored_start_busy", 32'(busy), 32'd0);

        run_op(3'd3, 32'd5, 32'd0, cyc);
        chk("divu0_lat", 32'(cyc), 32'd33);
        chk("divu0_lo", lo_out, 32'hFFFF_FFFF);
        chk("divu0_hi", hi_out, 32'd5);

        run_op(3'd2, 32'hFFFF_FFFB, 32'd0, cyc);
        chk("div0_lo", lo_out, 32'hFFFF_FFFF);
        chk("div0_hi", hi_out, 32'hFFFF_FFFB);

        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        chk("ovf_lo", lo_out, 32'h8000_0000);
        chk("ovf_hi", hi_out, 32'h0);

        run_op(3'd2, 32'd100, 32'hFFFF_FFF9, cyc);
        chk("div_mix_lo", lo_out, 32'hFFFF_FFF2);
        chk("div_mix_hi", hi_out, 32'd2);

        // Reset abort at DIV cycle 10
        start = 1'b1; op = 3'd2; op1 = 32'd100; op2 = 32'd7;
        tick();
        start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        chk("abort_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi_out, 32'h0);
        chk("abort_lo", lo_out, 32'h0);
        chk("abort_done", 32'(done), 32'd0);
        tick();
        chk("abort_done2", 32'(done), 32'd0);
        chk("abort_busy2", 32'(busy), 32'd0);

        start = 1'b1; op = 3'd4; op1 = 32'h1234_5678;
        chk("idle_stall", 32'(stall), 32'd0);
        tick();
        start = 1'b0;
        chk("mthi_hi", hi_out, 32'h1234_5678);
        chk("mthi_busy", 32'(busy), 32'd0);
        chk("mthi_done", 32'(done), 32'd0);

        start = 1'b1; op = 3'd5; op1 = 32'hCAFE_0001;
        tick();
        start = 1'b0;
        chk("mtlo_lo", lo_out, 32'hCAFE_0001);
        chk("mtlo_hi", hi_out, 32'h1234_5678);

        start = 1'b1; op = 3'd6; op1 = 32'h5555_5555; op2 = 32'd3;
        tick();
        start = 1'b0;
        chk("nop_busy", 32'(busy), 32'd0);
        chk("nop_hi", hi_out, 32'h1234_5678);
        chk("nop_lo", lo_out, 32'hCAFE_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
